gear_sequencer: RTL and testbench

GEAR_SEQUENCER -- requirements
Module: gear_sequencer

---
 rtl/gear_sequencer.sv | 261 ++++++++++++++++++++++++++
 tb/tb_gear_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gear_sequencer.sv
`default_nettype none
//============================================================================
//  Module   : gear_sequencer
//  Purpose  : Race sequencer for the shifting game. It runs a three-light
//             countdown, then drives gear selection and a gated throttle into
//             the rpm block. Each up-shift cuts the throttle for a fixed
//             number of cycles before the next gear engages.
//  Revision : 1.0  initial release
//----------------------------------------------------------------------------
//  Parameters
//    COUNT_TICKS  clock cycles per countdown light step
//    SHIFT_CUT    gas-cut cycles per gear shift
//    REDLINE_RPM  redline threshold (rpm >= REDLINE_RPM raises redline)
//  Ports
//    clk100Hz      in   clock
//    rst           in   synchronous active-high reset
//    start         in   race start / rearm request (level)
//    gas_btn       in   player throttle
//    shift_up      in   shift lever (level, rising edge = request)
//    finish        in   finish line reached
//    rpm[13:0]     in   engine speed from the rpm block
//    gear[1:0]     out  gear to the rpm block (0 = neutral, 1..3)
//    gas_key       out  gated throttle to the rpm block
//    reset_status  out  one-cycle clear pulse for the rpm block
//    state[1:0]    out  IDLE=0, COUNTDOWN=1, RACE=2, DONE=3
//    lights[1:0]   out  countdown lights remaining
//    shift_busy    out  gas cut in progress
//    redline       out  registered rpm >= REDLINE_RPM
//    false_start   out  sticky until rearm
//  Build options
//    AUTO_SHIFT_EN  when defined, a registered redline at gear < 3 raises
//                   a shift request in RACE alongside the manual lever.
//============================================================================
module gear_sequencer #(
  parameter int COUNT_TICKS = 100,
  parameter int SHIFT_CUT   = 20,
  parameter int REDLINE_RPM = 10500
) (
  input  logic        clk100Hz,
  input  logic        rst,
  input  logic        start,
  input  logic        gas_btn,
  input  logic        shift_up,
  input  logic        finish,
  input  logic [13:0] rpm,
  output logic [1:0]  gear,
  output logic        gas_key,
  output logic        reset_status,
  output logic [1:0]  state,
  output logic [1:0]  lights,
  output logic        shift_busy,
  output logic        redline,
  output logic        false_start
);

  // State encoding is visible on the state port, so it is fixed.
  localparam logic [1:0] c_ST_IDLE      = 2'd0;
  localparam logic [1:0] c_ST_COUNTDOWN = 2'd1;
  localparam logic [1:0] c_ST_RACE      = 2'd2;
  localparam logic [1:0] c_ST_DONE      = 2'd3;

  localparam logic [1:0] c_GEAR_N   = 2'd0;
  localparam logic [1:0] c_GEAR_1   = 2'd1;
  localparam logic [1:0] c_GEAR_TOP = 2'd3;
  localparam logic [1:0] c_GEAR_ONE = 2'd1;

  localparam logic [1:0] c_LIGHTS_FULL = 2'd3;
  localparam logic [1:0] c_LIGHTS_LAST = 2'd1;
  localparam logic [1:0] c_LIGHTS_OFF  = 2'd0;
  localparam logic [1:0] c_LIGHTS_ONE  = 2'd1;

  // Counter widths never collapse to zero even for a one-cycle setting.
  localparam int c_TICK_W = (COUNT_TICKS > 1) ? $clog2(COUNT_TICKS) : 1;
  localparam int c_CUT_W  = (SHIFT_CUT   > 1) ? $clog2(SHIFT_CUT)   : 1;

  localparam logic [c_TICK_W-1:0] c_TICK_MAX  = c_TICK_W'(COUNT_TICKS - 1);
  localparam logic [c_TICK_W-1:0] c_TICK_ZERO = '0;
  localparam logic [c_TICK_W-1:0] c_TICK_ONE  = c_TICK_W'(1);

  localparam logic [c_CUT_W-1:0]  c_CUT_LOAD  = c_CUT_W'(SHIFT_CUT - 1);
  localparam logic [c_CUT_W-1:0]  c_CUT_ZERO  = '0;
  localparam logic [c_CUT_W-1:0]  c_CUT_ONE   = c_CUT_W'(1);

  localparam logic [13:0] c_REDLINE = 14'(REDLINE_RPM);

  // Registered state
  logic [1:0]          r_state;
  logic [1:0]          r_gear;
  logic                r_gas_key;
  logic                r_reset_status;
  logic [1:0]          r_lights;
  logic                r_shift_busy;
  logic                r_redline;
  logic                r_false_start;
  logic [c_TICK_W-1:0] r_tick;
  logic [c_CUT_W-1:0]  r_cut;
  logic                r_shift_d;

  // Next-state values
  logic [1:0]          w_state_nxt;
  logic [1:0]          w_gear_nxt;
  logic                w_gas_key_nxt;
  logic                w_reset_status_nxt;
  logic [1:0]          w_lights_nxt;
  logic                w_shift_busy_nxt;
  logic                w_false_start_nxt;
  logic [c_TICK_W-1:0] w_tick_nxt;
  logic [c_CUT_W-1:0]  w_cut_nxt;

  logic w_shift_edge;
  logic w_auto_req;
  logic w_shift_req;

  // A lever held high only counts on its first cycle.
  assign w_shift_edge = shift_up & ~r_shift_d;

`ifdef AUTO_SHIFT_EN
  // Redline is the registered flag, so an auto shift lands one cycle after
  // the rpm sample that crossed the threshold.
  assign w_auto_req = r_redline & (r_gear != c_GEAR_TOP) & ~r_shift_busy;
`else
  assign w_auto_req = 1'b0;
`endif

  assign w_shift_req = w_shift_edge | w_auto_req;

  always_comb begin
    w_state_nxt        = r_state;
    w_gear_nxt         = r_gear;
    w_lights_nxt       = r_lights;
    w_shift_busy_nxt   = r_shift_busy;
    w_false_start_nxt  = r_false_start;
    w_tick_nxt         = r_tick;
    w_cut_nxt          = r_cut;
    w_reset_status_nxt = 1'b0;

    case (r_state)
      c_ST_IDLE: begin
        w_gear_nxt       = c_GEAR_N;
        w_shift_busy_nxt = 1'b0;
        w_cut_nxt        = c_CUT_ZERO;
        if (start) begin
          w_state_nxt  = c_ST_COUNTDOWN;
          w_lights_nxt = c_LIGHTS_FULL;
          w_tick_nxt   = c_TICK_ZERO;
        end
      end

      c_ST_COUNTDOWN: begin
        w_gear_nxt = c_GEAR_N;
        if (w_shift_edge) begin
          // Jumping the lights ends the attempt; lights freeze where they were.
          w_state_nxt       = c_ST_DONE;
          w_false_start_nxt = 1'b1;
          w_tick_nxt        = c_TICK_ZERO;
        end else if (r_tick == c_TICK_MAX) begin
          w_tick_nxt = c_TICK_ZERO;
          if (r_lights == c_LIGHTS_LAST) begin
            // Last light goes out and first gear engages together.
            w_state_nxt  = c_ST_RACE;
            w_lights_nxt = c_LIGHTS_OFF;
            w_gear_nxt   = c_GEAR_1;
          end else begin
            w_lights_nxt = r_lights - c_LIGHTS_ONE;
          end
        end else begin
          w_tick_nxt = r_tick + c_TICK_ONE;
        end
      end

      c_ST_RACE: begin
        if (finish) begin
          // Finish beats any shift; a cut in flight is dropped without
          // advancing the gear.
          w_state_nxt      = c_ST_DONE;
          w_shift_busy_nxt = 1'b0;
          w_cut_nxt        = c_CUT_ZERO;
        end else if (r_shift_busy) begin
          // Requests during a cut are discarded, not queued.
          if (r_cut == c_CUT_ZERO) begin
            w_shift_busy_nxt = 1'b0;
            w_gear_nxt       = r_gear + c_GEAR_ONE;
          end else begin
            w_cut_nxt = r_cut - c_CUT_ONE;
          end
        end else if (w_shift_req && (r_gear != c_GEAR_TOP)) begin
          w_shift_busy_nxt = 1'b1;
          w_cut_nxt        = c_CUT_LOAD;
        end
      end

      c_ST_DONE: begin
        w_shift_busy_nxt = 1'b0;
        w_cut_nxt        = c_CUT_ZERO;
        if (start) begin
          w_state_nxt        = c_ST_IDLE;
          w_reset_status_nxt = 1'b1;
          w_false_start_nxt  = 1'b0;
          w_gear_nxt         = c_GEAR_N;
          w_lights_nxt       = c_LIGHTS_OFF;
          w_tick_nxt         = c_TICK_ZERO;
        end
      end

      default: begin
        w_state_nxt = c_ST_IDLE;
      end
    endcase
  end

  // Throttle follows the state being entered so that it lines up with
  // gear and shift_busy on the same cycle.
  always_comb begin
    w_gas_key_nxt = 1'b0;
    case (w_state_nxt)
      c_ST_IDLE,
      c_ST_COUNTDOWN: w_gas_key_nxt = gas_btn;
      c_ST_RACE:      w_gas_key_nxt = gas_btn & ~w_shift_busy_nxt;
      default:        w_gas_key_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk100Hz) begin
    if (rst) begin
      r_state        <= c_ST_IDLE;
      r_gear         <= c_GEAR_N;
      r_gas_key      <= 1'b0;
      r_reset_status <= 1'b0;
      r_lights       <= c_LIGHTS_OFF;
      r_shift_busy   <= 1'b0;
      r_redline      <= 1'b0;
      r_false_start  <= 1'b0;
      r_tick         <= c_TICK_ZERO;
      r_cut          <= c_CUT_ZERO;
      r_shift_d      <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_gear         <= w_gear_nxt;
      r_gas_key      <= w_gas_key_nxt;
      r_reset_status <= w_reset_status_nxt;
      r_lights       <= w_lights_nxt;
      r_shift_busy   <= w_shift_busy_nxt;
      r_redline      <= (rpm >= c_REDLINE);
      r_false_start  <= w_false_start_nxt;
      r_tick         <= w_tick_nxt;
      r_cut          <= w_cut_nxt;
      r_shift_d      <= shift_up;
    end
  end

  assign gear         = r_gear;
  assign gas_key      = r_gas_key;
  assign reset_status = r_reset_status;
  assign state        = r_state;
  assign lights       = r_lights;
  assign shift_busy   = r_shift_busy;
  assign redline      = r_redline;
  assign false_start  = r_false_start;

endmodule
`default_nettype wire

// File: tb/tb_gear_sequencer.sv
`default_nettype none
//============================================================================
//  Module   : tb_gear_sequencer
//  Purpose  : Self-checking bench for gear_sequencer (COUNT_TICKS=4,
//             SHIFT_CUT=3). A timestamp-based reference model predicts every
//             output after each clock edge; directed steps cover the race
//             flow and corner cases, followed by a randomized run.
//  Revision : 1.0  initial release
//  Build options
//    AUTO_SHIFT_EN  expectations follow the DUT build option of that name.
//============================================================================
module tb_gear_sequencer;

  localparam int CT = 4;
  localparam int SC = 3;
  localparam int RL = 10500;

  logic        clk100Hz = 1'b0;
  logic        rst      = 1'b1;
  logic        start    = 1'b0;
  logic        gas_btn  = 1'b0;
  logic        shift_up = 1'b0;
  logic        finish   = 1'b0;
  logic [13:0] rpm      = '0;
  logic [1:0]  gear;
  logic        gas_key;
  logic        reset_status;
  logic [1:0]  state;
  logic [1:0]  lights;
  logic        shift_busy;
  logic        redline;
  logic        false_start;

  int n_asserts = 0;
  int n_fail    = 0;

  gear_sequencer #(
    .COUNT_TICKS (CT),
    .SHIFT_CUT   (SC),
    .REDLINE_RPM (RL)
  ) dut (
    .clk100Hz     (clk100Hz),
    .rst          (rst),
    .start        (start),
    .gas_btn      (gas_btn),
    .shift_up     (shift_up),
    .finish       (finish),
    .rpm          (rpm),
    .gear         (gear),
    .gas_key      (gas_key),
    .reset_status (reset_status),
    .state        (state),
    .lights       (lights),
    .shift_busy   (shift_busy),
    .redline      (redline),
    .false_start  (false_start)
  );

  always #5 clk100Hz = ~clk100Hz;

  // Reference model: phases as plain integers, countdown lights derived from
  // elapsed time since entry, gear-shift completion as an absolute cycle.
  int m_n        = 0;   // clock edges seen
  int m_phase    = 0;   // 0 idle, 1 countdown, 2 race, 3 done
  int m_gear     = 0;
  int m_cd_entry = 0;   // edge on which the countdown began
  int m_cut_done = 0;   // edge on which the pending gear engages
  int m_lt_done  = 0;   // lights shown while in DONE
  bit m_cut      = 1'b0;
  bit m_false    = 1'b0;
  bit m_pulse    = 1'b0;
  bit m_red      = 1'b0;
  bit m_prev_sh  = 1'b0;
  bit m_in_rst   = 1'b1;

  function automatic int cd_lights(input int edge_idx);
    return 3 - (edge_idx - m_cd_entry) / CT;
  endfunction

  task automatic model_step();
    bit sh_edge;
    bit red_prev;
    bit req;
    m_n++;
    if (rst) begin
      m_phase = 0; m_gear = 0; m_cut = 0; m_false = 0; m_pulse = 0;
      m_red = 0; m_prev_sh = 0; m_lt_done = 0; m_in_rst = 1;
      return;
    end
    m_in_rst  = 0;
    sh_edge   = shift_up && !m_prev_sh;
    m_prev_sh = shift_up;
    red_prev  = m_red;
    m_red     = (int'(rpm) >= RL);
    m_pulse   = 0;
    case (m_phase)
      0: if (start) begin m_phase = 1; m_cd_entry = m_n; end
      1: begin
        if (sh_edge) begin
          m_lt_done = cd_lights(m_n - 1);
          m_phase = 3; m_false = 1; m_gear = 0;
        end else if (m_n - m_cd_entry >= 3 * CT) begin
          m_phase = 2; m_gear = 1;
        end
      end
      2: begin
        req = sh_edge;
`ifdef AUTO_SHIFT_EN
        req = req || red_prev;
`endif
        if (finish) begin
          m_phase = 3; m_cut = 0; m_lt_done = 0;
        end else if (m_cut) begin
          if (m_n == m_cut_done) begin m_gear++; m_cut = 0; end
        end else if (req && m_gear < 3) begin
          m_cut = 1; m_cut_done = m_n + SC;
        end
      end
      default: if (start) begin
        m_phase = 0; m_pulse = 1; m_false = 0; m_gear = 0;
      end
    endcase
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    int exp_lt;
    bit exp_gas;
    case (m_phase)
      1:       exp_lt = cd_lights(m_n);
      3:       exp_lt = m_lt_done;
      default: exp_lt = 0;
    endcase
    case (m_phase)
      0, 1:    exp_gas = gas_btn;
      2:       exp_gas = gas_btn && !m_cut;
      default: exp_gas = 0;
    endcase
    if (m_in_rst) exp_gas = 0;
    chk("state",        16'(state),        16'(m_phase));
    chk("gear",         16'(gear),         16'(m_gear));
    chk("lights",       16'(lights),       16'(exp_lt));
    chk("gas_key",      16'(gas_key),      16'(exp_gas));
    chk("reset_status", 16'(reset_status), 16'(m_pulse));
    chk("shift_busy",   16'(shift_busy),   16'(m_cut));
    chk("redline",      16'(redline),      16'(m_red));
    chk("false_start",  16'(false_start),  16'(m_false));
  endtask

  // One clock: inputs already driven, sample 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk100Hz);
    #1;
    model_step();
    check_all();
  endtask

  task automatic cycles(input int k);
    for (int i = 0; i < k; i++) cyc();
  endtask

  // Rearm from DONE and run a full countdown into RACE at gear 1.
  task automatic to_race();
    start = 1; cyc(); start = 0;
    cycles(12);
  endtask

  initial begin
    // Reset state
    cycles(2);
    chk("rst_state", 16'(state), 16'd0);
    chk("rst_gear",  16'(gear),  16'd0);
    chk("rst_lights", 16'(lights), 16'd0);
    rst = 0;

    // Neutral revving in IDLE
    gas_btn = 1; cyc();
    chk("idle_gas", 16'(gas_key), 16'd1);

    // Countdown 3,2,1 at 4 cycles each, RACE 12 cycles after entry
    start = 1; cyc(); start = 0;
    chk("cd_entry_lights", 16'(lights), 16'd3);
    cycles(11);
    chk("cd_last_light", 16'(lights), 16'd1);
    chk("cd_still_state", 16'(state), 16'd1);
    cyc();
    chk("race_state", 16'(state), 16'd2);
    chk("race_gear",  16'(gear),  16'd1);

    // Manual shift 1->2, lever held high afterwards
    shift_up = 1; cyc();
    chk("cut_busy", 16'(shift_busy), 16'd1);
    chk("cut_gas",  16'(gas_key),    16'd0);
    cycles(2);
    chk("cut_busy_end", 16'(shift_busy), 16'd1);
    cyc();
    chk("shift2_gear", 16'(gear),    16'd2);
    chk("shift2_gas",  16'(gas_key), 16'd1);
    cycles(3);
    chk("held_lever_gear", 16'(gear), 16'd2);

    // Edge during a cut is ignored
    shift_up = 0; cyc();
    shift_up = 1; cyc();
    shift_up = 0; cyc();
    shift_up = 1; cyc();
    chk("edge_in_cut_busy", 16'(shift_busy), 16'd1);
    cyc();
    chk("shift3_gear", 16'(gear), 16'd3);
    cycles(4);
    chk("no_queue_gear", 16'(gear), 16'd3);

    // Edge at gear 3 is ignored
    shift_up = 0; cyc();
    shift_up = 1; cyc();
    chk("top_gear_busy", 16'(shift_busy), 16'd0);

    // Finish, then rearm
    finish = 1; cyc(); finish = 0;
    chk("done_state", 16'(state),   16'd3);
    chk("done_gas",   16'(gas_key), 16'd0);
    chk("done_gear",  16'(gear),    16'd3);
    start = 1; cyc(); start = 0;
    chk("rearm_state", 16'(state),        16'd0);
    chk("rearm_pulse", 16'(reset_status), 16'd1);
    cyc();
    chk("pulse_once", 16'(reset_status), 16'd0);

    // False start at lights=2
    shift_up = 0;
    start = 1; cyc(); start = 0;
    cycles(4);
    chk("fs_lights", 16'(lights), 16'd2);
    shift_up = 1; cyc();
    chk("fs_flag",  16'(false_start), 16'd1);
    chk("fs_state", 16'(state),       16'd3);
    cycles(3);
    chk("fs_sticky", 16'(false_start), 16'd1);
    start = 1; cyc(); start = 0;
    chk("fs_clear", 16'(false_start), 16'd0);
    chk("fs_pulse", 16'(reset_status), 16'd1);

    // Finish and shift edge in the same RACE cycle
    shift_up = 0;
    to_race();
    finish = 1; shift_up = 1; cyc(); finish = 0;
    chk("fin_shift_state", 16'(state), 16'd3);
    chk("fin_shift_gear",  16'(gear),  16'd1);
    chk("fin_shift_gas",   16'(gas_key), 16'd0);

    // Finish aborts a cut in flight
    start = 1; cyc(); start = 0;
    shift_up = 0;
    to_race();
    shift_up = 1; cyc();
    cyc();
    finish = 1; cyc(); finish = 0;
    chk("abort_gear", 16'(gear),       16'd1);
    chk("abort_busy", 16'(shift_busy), 16'd0);

    // Redline threshold and optional automatic shift at gear 2
    start = 1; cyc(); start = 0;
    shift_up = 0;
    to_race();
    shift_up = 1; cycles(4);
    chk("pre_auto_gear", 16'(gear), 16'd2);
    rpm = 14'd10499; cycles(6);
    chk("below_red", 16'(redline), 16'd0);
    chk("below_red_gear", 16'(gear), 16'd2);
    rpm = 14'd10600; cyc();
    chk("above_red", 16'(redline), 16'd1);
    cyc();
`ifdef AUTO_SHIFT_EN
    chk("auto_busy", 16'(shift_busy), 16'd1);
    cycles(3);
    chk("auto_gear", 16'(gear), 16'd3);
`else
    chk("manual_only_busy", 16'(shift_busy), 16'd0);
    cycles(3);
    chk("manual_only_gear", 16'(gear), 16'd2);
`endif
    rpm = 14'd0;

    // Reset mid-countdown, with start asserted in the same cycle
    finish = 1; cyc(); finish = 0;
    start = 1; cyc(); start = 0;
    shift_up = 0;
    start = 1; cyc(); start = 0;
    cycles(5);
    rst = 1; start = 1; cyc();
    chk("rst_cd_state",  16'(state),  16'd0);
    chk("rst_cd_lights", 16'(lights), 16'd0);
    rst = 0; start = 0; cyc();

    // Reset mid-shift, with finish asserted in the same cycle
    start = 1; cyc(); start = 0;
    cycles(12);
    shift_up = 1; cyc();
    rst = 1; finish = 1; cyc();
    chk("rst_sh_busy", 16'(shift_busy), 16'd0);
    chk("rst_sh_gear", 16'(gear),       16'd0);
    rst = 0; finish = 0; shift_up = 0; cyc();

    // Randomized run
    for (int i = 0; i < 1500; i++) begin
      rst     = ($urandom_range(0, 199) == 0);
      start   = ($urandom_range(0, 15) == 0);
      gas_btn = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) shift_up = ~shift_up;
      finish  = ($urandom_range(0, 39) == 0);
      rpm     = 14'(10300 + $urandom_range(0, 400));
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
